tone_reproduction_sched: RTL and testbench

Sequenced controller for the piecewise-linear tone-reproduction stage. It accepts one pixel (luminance L plus R/G/B) per valid/ready handshake and classifies L into one of four segments using programmable breakpoints. It then applies that segment's slope/offset to R, G and B through a single shared multiplier, one channel per cycle, and presents the result on a valid/ready output. It sits between the luminance/colour front end and the pixel output stage, and it owns the runtime-writable breakpoint and coefficient registers for the curve.

---
 rtl/tone_reproduction_sched.sv | 171 +++++++++++++++++
 tb/tb_tone_reproduction_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_reproduction_sched.sv
//------------------------------------------------------------------------------
// tone_reproduction_sched: piecewise-linear tone curve, one shared multiplier.
// Optional macro TONE_SAT_EN clamps (product>>FRAC_W)+b instead of wrapping.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tone_reproduction_sched #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_l,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b,
  output logic              busy
);

  localparam logic [DATA_W-1:0] C_L1X_RST = DATA_W'(32'd8127);
  localparam logic [DATA_W-1:0] C_L2X_RST = DATA_W'(32'd16255);
  localparam logic [DATA_W-1:0] C_L3X_RST = DATA_W'(32'd81275);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEG  = 3'd1,
    S_MR   = 3'd2,
    S_MG   = 3'd3,
    S_MB   = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_l1x, r_l2x, r_l3x;
  logic [DATA_W-1:0] r_a [4];
  logic [DATA_W-1:0] r_b [4];
  logic [DATA_W-1:0] r_l, r_r, r_g, r_b_ch;
  logic [DATA_W-1:0] r_a_sel, r_b_sel;

  logic [1:0]          w_seg;
  logic [DATA_W-1:0]   w_ch;
  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_shift;
  logic [2*DATA_W:0]   w_sum;
  logic [DATA_W-1:0]   w_res;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_SEG;
      S_SEG:   w_state_nxt = S_MR;
      S_MR:    w_state_nxt = S_MG;
      S_MG:    w_state_nxt = S_MB;
      S_MB:    w_state_nxt = S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);

  // Priority classification; breakpoints may be unordered.
  always_comb begin
    w_seg = 2'd3;
    if      (r_l <= r_l1x) w_seg = 2'd0;
    else if (r_l <= r_l2x) w_seg = 2'd1;
    else if (r_l <= r_l3x) w_seg = 2'd2;
  end

  always_comb begin
    w_ch = r_r;
    case (r_state)
      S_MG:    w_ch = r_g;
      S_MB:    w_ch = r_b_ch;
      default: w_ch = r_r;
    endcase
  end

  assign w_prod  = {{DATA_W{1'b0}}, w_ch} * {{DATA_W{1'b0}}, r_a_sel};
  assign w_shift = w_prod >> FRAC_W;
  assign w_sum   = {1'b0, w_shift} + {{(DATA_W+1){1'b0}}, r_b_sel};

`ifdef TONE_SAT_EN
  assign w_res = (|w_sum[2*DATA_W:DATA_W]) ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_sum[2*DATA_W:DATA_W];
  assign w_res       = w_sum[DATA_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_l1x   <= C_L1X_RST;
      r_l2x   <= C_L2X_RST;
      r_l3x   <= C_L3X_RST;
      r_a[0]  <= DATA_W'(32'd512);
      r_a[1]  <= DATA_W'(32'd384);
      r_a[2]  <= DATA_W'(32'd240);
      r_a[3]  <= DATA_W'(32'd230);
      r_b[0]  <= '0;
      r_b[1]  <= DATA_W'(32'd640);
      r_b[2]  <= DATA_W'(32'd2080);
      r_b[3]  <= DATA_W'(32'd2560);
      r_l     <= '0;
      r_r     <= '0;
      r_g     <= '0;
      r_b_ch  <= '0;
      r_a_sel <= '0;
      r_b_sel <= '0;
      out_r   <= '0;
      out_g   <= '0;
      out_b   <= '0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          4'd0:    r_l1x  <= cfg_wdata;
          4'd1:    r_l2x  <= cfg_wdata;
          4'd2:    r_l3x  <= cfg_wdata;
          4'd3:    r_a[0] <= cfg_wdata;
          4'd4:    r_a[1] <= cfg_wdata;
          4'd5:    r_a[2] <= cfg_wdata;
          4'd6:    r_a[3] <= cfg_wdata;
          4'd7:    r_b[0] <= cfg_wdata;
          4'd8:    r_b[1] <= cfg_wdata;
          4'd9:    r_b[2] <= cfg_wdata;
          4'd10:   r_b[3] <= cfg_wdata;
          default: ;
        endcase
      end
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_l    <= in_l;
          r_r    <= in_r;
          r_g    <= in_g;
          r_b_ch <= in_b;
        end
        // Coefficients are frozen here so later cfg writes only affect the next pixel.
        S_SEG: begin
          r_a_sel <= r_a[w_seg];
          r_b_sel <= r_b[w_seg];
        end
        S_MR:    out_r <= w_res;
        S_MG:    out_g <= w_res;
        S_MB:    out_b <= w_res;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tone_reproduction_sched.sv
//------------------------------------------------------------------------------
// tb_tone_reproduction_sched: directed bench for tone_reproduction_sched.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tone_reproduction_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        in_valid, in_ready;
  logic [31:0] in_l, in_r, in_g, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_r, out_g, out_b;
  logic        busy;

  logic        cfg16_we;
  logic [3:0]  cfg16_addr;
  logic [15:0] cfg16_wdata;
  logic        in16_valid, in16_ready;
  logic [15:0] in16_l, in16_r, in16_g, in16_b;
  logic        out16_valid, out16_ready;
  logic [15:0] out16_r, out16_g, out16_b;
  logic        busy16;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int lat;

  always #5 clk = ~clk;

  tone_reproduction_sched #(.DATA_W(32), .FRAC_W(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_l(in_l), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .busy(busy)
  );

  tone_reproduction_sched #(.DATA_W(16), .FRAC_W(8)) dut16 (
    .clk(clk), .rst(rst),
    .cfg_we(cfg16_we), .cfg_addr(cfg16_addr), .cfg_wdata(cfg16_wdata),
    .in_valid(in16_valid), .in_ready(in16_ready),
    .in_l(in16_l), .in_r(in16_r), .in_g(in16_g), .in_b(in16_b),
    .out_valid(out16_valid), .out_ready(out16_ready),
    .out_r(out16_r), .out_g(out16_g), .out_b(out16_b),
    .busy(busy16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r,
                      input logic [31:0] g, input logic [31:0] b);
    in_l = l; in_r = r; in_g = g; in_b = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Returns the cycle index (accept edge + lat) at which out_valid is seen.
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_l = '0; in_r = '0; in_g = '0; in_b = '0;
    out_ready = 1'b1;
    cfg16_we = 1'b0; cfg16_addr = '0; cfg16_wdata = '0;
    in16_valid = 1'b0; in16_l = '0; in16_r = '0; in16_g = '0; in16_b = '0;
    out16_ready = 1'b1;

    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_r", out_r, 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Segment 3 pixel, latency
    send(32'd65019, 32'd32768, 32'd23040, 32'd19968);
    wait_out(lat);
    check("seg3_latency", 32'(lat), 32'd5);
    check("seg3_r", out_r, 32'd32800);
    check("seg3_g", out_g, 32'd23680);
    check("seg3_b", out_b, 32'd20800);
    step();
    check("idle_after_out", 32'(busy), 32'd0);

    // Breakpoint boundary
    send(32'd8127, 32'd100, 32'd100, 32'd100);
    wait_out(lat);
    check("bnd_seg1_r", out_r, 32'd200);
    check("bnd_seg1_g", out_g, 32'd200);
    check("bnd_seg1_b", out_b, 32'd200);
    step();
    send(32'd8128, 32'd100, 32'd100, 32'd100);
    wait_out(lat);
    check("bnd_seg2_r", out_r, 32'd790);
    check("bnd_seg2_g", out_g, 32'd790);
    check("bnd_seg2_b", out_b, 32'd790);
    step();

    // Back-pressure
    out_ready = 1'b0;
    send(32'd0, 32'd7, 32'd8, 32'd9);
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'd5);
    in_l = 32'd8128; in_r = 32'd1000; in_g = 32'd0; in_b = 32'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_r", out_r, 32'd14);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    check("bp_hold_g", out_g, 32'd16);
    check("bp_hold_b", out_b, 32'd18);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_no_early_accept", 32'(busy), 32'd0);
    step();
    in_valid = 1'b0;
    check("bp_accept_after", 32'(busy), 32'd1);
    wait_out(lat);
    check("bp_second_r", out_r, 32'd2140);
    step();

    // Reconfig while pixel is in MG/MB
    send(32'd65019, 32'd1000, 32'd2000, 32'd3000);
    step(); step();
    cfg_write(4'd5, 32'd256);
    cfg_write(4'd9, 32'd0);
    wait_out(lat);
    check("recfg_old_r", out_r, 32'd3017);
    check("recfg_old_g", out_g, 32'd3955);
    check("recfg_old_b", out_b, 32'd4892);
    step();
    send(32'd65019, 32'd1000, 32'd2000, 32'd0);
    wait_out(lat);
    check("recfg_new_r", out_r, 32'd1000);
    check("recfg_new_g", out_g, 32'd2000);
    step();

    // Reset mid-operation, after moving L1x away from its default
    cfg_write(4'd0, 32'd0);
    send(32'd8127, 32'd100, 32'd100, 32'd100);
    step(); step();
    rst = 1'b1;
    step();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_r", out_r, 32'd0);
    send(32'd8127, 32'd100, 32'd100, 32'd100);
    wait_out(lat);
    check("midrst_l1x_default", out_r, 32'd200);
    step();
    send(32'd65019, 32'd1000, 32'd0, 32'd0);
    wait_out(lat);
    check("midrst_a3_default", out_r, 32'd3017);
    step();

    // 16-bit instance: overflow handling in segment 4
    cfg16_addr = 4'd10; cfg16_wdata = 16'd10000; cfg16_we = 1'b1;
    step();
    cfg16_we = 1'b0;
    in16_l = 16'd65535; in16_r = 16'd65535; in16_g = 16'd100; in16_b = 16'd0;
    in16_valid = 1'b1;
    step();
    in16_valid = 1'b0;
    lat = 1;
    while (!out16_valid && lat < 20) begin
      step();
      lat++;
    end
    check("w16_latency", 32'(lat), 32'd5);
`ifdef TONE_SAT_EN
    check("w16_ovf_r", 32'(out16_r), 32'd65535);
`else
    check("w16_ovf_r", 32'(out16_r), 32'd3343);
`endif
    check("w16_g", 32'(out16_g), 32'd10089);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
